// File: rtl/mandel_pkg.sv
// mandel_pkg: shared widths, escape threshold, FSM encoding and {im, re} helpers
// for the escape-time engine. Optional feature macro: MANDEL_JULIA_EN.
package mandel_pkg;

  localparam int WS = 16;
  localparam int DP = 8;
  localparam int IW = 8;

  // |z|^2 must strictly exceed 4.0 to count as escaped
  localparam int ESC_THRESH = 4 << DP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [WS-1:0] fix_t;
  typedef struct packed {
    fix_t im;
    fix_t re;
  } cplx_t;

  function automatic fix_t cplx_re(input logic [2*WS-1:0] c);
    return c[WS-1:0];
  endfunction

  function automatic fix_t cplx_im(input logic [2*WS-1:0] c);
    return c[2*WS-1:WS];
  endfunction

  function automatic logic [2*WS-1:0] cplx_pack(input fix_t im, input fix_t re);
    return {im, re};
  endfunction

endpackage

// File: rtl/mandel_iter_engine_if.sv
// Point-in / result-out handshake bundle for mandel_iter_engine.
// MANDEL_JULIA_EN adds the Julia-mode select and additive constant.
interface mandel_iter_engine_if #(
  parameter int ws = 16,
  parameter int iw = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [2*ws-1:0] c_in;
  logic [iw-1:0]   max_iter;
  logic            out_valid;
  logic            out_ready;
  logic [iw-1:0]   iter_count;
  logic            escaped;
`ifdef MANDEL_JULIA_EN
  logic            mode_julia;
  logic [2*ws-1:0] k_in;

  modport master (
    output in_valid, c_in, max_iter, out_ready, mode_julia, k_in,
    input  in_ready, out_valid, iter_count, escaped
  );
  modport slave (
    input  in_valid, c_in, max_iter, out_ready, mode_julia, k_in,
    output in_ready, out_valid, iter_count, escaped
  );
`else
  modport master (
    output in_valid, c_in, max_iter, out_ready,
    input  in_ready, out_valid, iter_count, escaped
  );
  modport slave (
    input  in_valid, c_in, max_iter, out_ready,
    output in_ready, out_valid, iter_count, escaped
  );
`endif
endinterface

// File: rtl/mandel_step.sv
// mandel_step: one combinational z <- z^2 + c step plus the escape test on the
// current z. Products use fixMul semantics: full signed product, arithmetic
// shift by dp, truncate to ws. Sums wrap two's complement.
module mandel_step
  import mandel_pkg::*;
#(
  parameter int ws = WS,
  parameter int dp = DP
) (
  input  logic [2*ws-1:0] z,
  input  logic [2*ws-1:0] c,
  output logic [2*ws-1:0] z_next,
  output logic            esc
);

  localparam logic signed [ws+1:0] THR = (ws+2)'(4 << dp);

  // (a*b)>>>dp truncated to ws
  function automatic logic signed [ws-1:0] fix_mul(input logic signed [ws-1:0] a,
                                                   input logic signed [ws-1:0] b);
    logic signed [2*ws-1:0] p;
    p = a * b;
    return p[dp+ws-1:dp];
  endfunction

  // (2*a*b)>>>dp truncated to ws; doubling is a one-bit shift of the slice
  function automatic logic signed [ws-1:0] fix_mul2(input logic signed [ws-1:0] a,
                                                    input logic signed [ws-1:0] b);
    logic signed [2*ws-1:0] p;
    p = a * b;
    return p[dp+ws-2:dp-1];
  endfunction

  logic signed [ws-1:0] z_re, z_im, c_re, c_im;
  logic signed [ws-1:0] sq_re, sq_im, x_ri;
  logic signed [ws+1:0] mag;

  assign z_re = z[ws-1:0];
  assign z_im = z[2*ws-1:ws];
  assign c_re = c[ws-1:0];
  assign c_im = c[2*ws-1:ws];

  assign sq_re = fix_mul(z_re, z_re);
  assign sq_im = fix_mul(z_im, z_im);
  assign x_ri  = fix_mul2(z_re, z_im);

  // magnitude sum widened by two bits so it cannot wrap
  assign mag = (ws+2)'(sq_re) + (ws+2)'(sq_im);
  assign esc = mag > THR;

  assign z_next[ws-1:0]    = sq_re - sq_im + c_re;
  assign z_next[2*ws-1:ws] = x_ri + c_im;

endmodule

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: escape-time iterator, one point in flight.
// IDLE accepts a point, ITER performs one check/update per cycle, DONE holds
// the result until the consumer takes it.
// Optional feature macro: MANDEL_JULIA_EN (Julia mode: z0 = c_in, constant = k_in).
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int ws = WS,
  parameter int dp = DP,
  parameter int iw = IW
) (
  input logic                 clk,
  input logic                 rst,
  mandel_iter_engine_if.slave bus
);

  state_t          state;
  logic [2*ws-1:0] z, c;
  logic [iw-1:0]   n, lim;
  logic [iw-1:0]   cnt_q;
  logic            esc_q, in_rdy_q, out_vld_q;

  logic [2*ws-1:0] z_next;
  logic            step_esc;
  logic [2*ws-1:0] z0, k0;

  mandel_step #(.ws(ws), .dp(dp)) u_step (
    .z      (z),
    .c      (c),
    .z_next (z_next),
    .esc    (step_esc)
  );

`ifdef MANDEL_JULIA_EN
  assign z0 = bus.mode_julia ? bus.c_in : '0;
  assign k0 = bus.mode_julia ? bus.k_in : bus.c_in;
`else
  assign z0 = '0;
  assign k0 = bus.c_in;
`endif

  assign bus.in_ready   = in_rdy_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.iter_count = cnt_q;
  assign bus.escaped    = esc_q;

  // handshake FSM with registered outputs; escape wins over the limit test
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      cnt_q     <= '0;
      esc_q     <= 1'b0;
      z         <= '0;
      c         <= '0;
      n         <= '0;
      lim       <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          c        <= k0;
          z        <= z0;
          lim      <= bus.max_iter;
          n        <= '0;
          in_rdy_q <= 1'b0;
          state    <= ITER;
        end
        ITER: if (step_esc) begin
          esc_q     <= 1'b1;
          cnt_q     <= n;
          out_vld_q <= 1'b1;
          state     <= DONE;
        end else if (n == lim) begin
          esc_q     <= 1'b0;
          cnt_q     <= n;
          out_vld_q <= 1'b1;
          state     <= DONE;
        end else begin
          z <= z_next;
          n <= n + 1'b1;
        end
        DONE: if (bus.out_ready) begin
          out_vld_q <= 1'b0;
          in_rdy_q  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Bench for mandel_iter_engine: directed vector table, backpressure and
// mid-run reset sequences, then random points against a plain-arithmetic
// escape-time model.
module tb_mandel_iter_engine;
  import mandel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mandel_iter_engine_if #(.ws(16), .iw(8)) bus ();

  mandel_iter_engine #(.ws(16), .dp(8), .iw(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] c;
    int          m;
    int          cnt;
    bit          esc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int s16(input longint x);
    logic [15:0] t;
    t = x[15:0];
    return int'($signed(t));
  endfunction

  // escape-time reference: Q8.8 values held as plain integers
  function automatic void model(input logic [31:0] c, input int m,
                                output int cnt, output bit esc);
    longint zr, zi, cr, ci, sr, si, nr, ni;
    zr = 0; zi = 0;
    cr = s16(longint'(c[15:0]));
    ci = s16(longint'(c[31:16]));
    cnt = 0; esc = 0;
    for (int n = 0; n <= 255; n++) begin
      sr = s16((zr * zr) >>> 8);
      si = s16((zi * zi) >>> 8);
      if (sr + si > 1024) begin cnt = n; esc = 1; return; end
      if (n == m) begin cnt = n; esc = 0; return; end
      nr = s16(sr - si + cr);
      ni = s16(((2 * zr * zi) >>> 8) + ci);
      zr = nr; zi = ni;
    end
  endfunction

  task automatic send(input string tag, input logic [31:0] c, input int m);
    @(negedge clk);
    chk({tag, " in_ready"}, int'(bus.in_ready), 1);
    bus.c_in     = c;
    bus.max_iter = m[7:0];
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // count edges after the accept edge until out_valid shows
  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid) begin
      @(posedge clk);
      #1 lat++;
      if (lat > 400) begin
        chk({tag, " timeout"}, lat, -1);
        return;
      end
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run_point(input string tag, input logic [31:0] c, input int m,
                           input int cnt, input bit esc);
    int lat;
    send(tag, c, m);
    wait_result(tag, lat);
    chk({tag, " iter_count"}, int'(bus.iter_count), cnt);
    chk({tag, " escaped"}, int'(bus.escaped), int'(esc));
    chk({tag, " latency"}, lat, cnt + 1);
    pop();
  endtask

  vec_t vecs[7];

  initial begin
    int   mc;
    bit   me;
    logic [15:0] rr, ri;
    int   mm;

    vecs[0] = '{32'h0000_0200, 20, 2, 1'b1};
    vecs[1] = '{32'h0000_FE00, 20, 20, 1'b0};
    vecs[2] = '{32'h0100_0000, 50, 50, 1'b0};
    vecs[3] = '{32'h0000_0100, 0, 0, 1'b0};
    vecs[4] = '{32'h0000_0100, 10, 3, 1'b1};
    vecs[5] = '{32'h0000_0000, 255, 255, 1'b0};
    vecs[6] = '{32'h0200_0000, 20, 2, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.c_in      = '0;
    bus.max_iter  = '0;
`ifdef MANDEL_JULIA_EN
    bus.mode_julia = 1'b0;
    bus.k_in       = '0;
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset iter_count", int'(bus.iter_count), 0);
    chk("reset escaped", int'(bus.escaped), 0);

    foreach (vecs[i])
      run_point($sformatf("vec%0d", i), vecs[i].c, vecs[i].m, vecs[i].cnt, vecs[i].esc);

    // backpressure: result held, no second accept, next point right after pop
    send("bp", 32'h0000_0200, 20);
    wait_result("bp", mc);
    bus.c_in     = 32'h0000_0000;
    bus.max_iter = 8'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp out_valid", int'(bus.out_valid), 1);
      chk("bp iter_count", int'(bus.iter_count), 2);
      chk("bp escaped", int'(bus.escaped), 1);
      chk("bp in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    pop();
    chk("bp popped out_valid", int'(bus.out_valid), 0);
    chk("bp popped in_ready", int'(bus.in_ready), 1);
    run_point("bp next", 32'h0000_0100, 10, 3, 1'b1);

    // reset in the middle of a long in-set run
    send("rst", 32'h0000_0000, 100);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst in_ready", int'(bus.in_ready), 1);
    chk("rst out_valid", int'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("rst no result", int'(bus.out_valid), 0);
    end
    run_point("rst next", 32'h0000_0200, 20, 2, 1'b1);

    // random points with |re|,|im| <= 2.0
    for (int i = 0; i < 40; i++) begin
      rr = 16'($urandom_range(1024)) - 16'd512;
      ri = 16'($urandom_range(1024)) - 16'd512;
      mm = int'($urandom_range(60));
      model({ri, rr}, mm, mc, me);
      run_point($sformatf("rnd%0d c=%h m=%0d", i, {ri, rr}, mm), {ri, rr}, mm, mc, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
